// File: rtl/frac_bcd_seq.sv
// frac_bcd_seq: sequential binary-to-BCD converter for the fraction digits.
// The rounded binary fraction is converted by double dabble, one bit per
// clock, into packed BCD digits. The result and the leading-zero count are
// handed to the formatter over a valid/ready handshake.
// Optional feature macro: FRAC_RANGE_CHECK_EN adds the out_ovf port and
// saturates bcd_out to all nines when the value needs a sixth digit.
module frac_bcd_seq #(
    parameter int NBITS   = 17,
    parameter int NDIGITS = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [23:0]            frac_in,
    input  logic [4:0]             zero_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NDIGITS-1:0]   bcd_out,
    output logic [4:0]             zero_out,
    output logic                   busy
`ifdef FRAC_RANGE_CHECK_EN
    ,
    output logic                   out_ovf
`endif
);

    // One guard digit above the presented digits catches values >= 10^NDIGITS.
    localparam int ACC_W = 4 * (NDIGITS + 1);
    localparam int BCD_W = 4 * NDIGITS;
    localparam int CNT_W = $clog2(NBITS + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [4:0]       zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [NBITS-1:0] bin_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_adj;
    logic [ACC_W-1:0] acc_shift;

    logic             accept;
    logic             shifting;

    // Bits of frac_in above NBITS carry no information for this stage.
    logic             unused_frac_hi;
    assign unused_frac_hi = ^frac_in[23:NBITS];

    // Add 3 to every BCD nibble that is 5 or more, so the following left
    // shift carries correctly into the next decimal digit.
    function automatic logic [ACC_W-1:0] dabble_adj(input logic [ACC_W-1:0] a);
        logic [ACC_W-1:0] r;
        r = a;
        for (int i = 0; i < NDIGITS + 1; i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

`ifdef FRAC_RANGE_CHECK_EN
    // Saturate to all nines when the guard digit is non-zero; returns {ovf, digits}.
    function automatic logic [BCD_W:0] range_sat(input logic [ACC_W-1:0] a);
        logic [BCD_W:0] r;
        if (a[ACC_W-1:BCD_W] != 4'd0) begin
            r = {1'b1, {NDIGITS{4'h9}}};
        end else begin
            r = {1'b0, a[BCD_W-1:0]};
        end
        return r;
    endfunction
`endif

    assign accept   = (state_q == S_IDLE) && in_valid;
    assign shifting = (state_q == S_SHIFT) && (cnt_q != '0);

    // One double-dabble step: adjust nibbles, then shift {acc, bin} left by one.
    always_comb begin
        acc_adj   = dabble_adj(acc_q);
        acc_shift = (acc_adj << 1) | ACC_W'(bin_q[NBITS-1]);
    end

    // Next-state and result-capture logic for the IDLE/SHIFT/DONE sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_SHIFT;
                    cnt_d   = CNT_W'(NBITS);
                    zero_d  = zero_in;
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    // All bits consumed: capture the digits on entry to DONE.
                    state_d = S_DONE;
`ifdef FRAC_RANGE_CHECK_EN
                    {ovf_d, bcd_d} = range_sat(acc_q);
`else
                    bcd_d = acc_q[BCD_W-1:0];
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and presented-result registers; reset aborts any conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bcd_q   <= '0;
            zero_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    // Conversion datapath: load on accept, shift while bits remain.
    always_ff @(posedge clk) begin
        if (accept) begin
            bin_q <= frac_in[NBITS-1:0];
            acc_q <= '0;
        end else if (shifting) begin
            bin_q <= bin_q << 1;
            acc_q <= acc_shift;
        end
    end

    // Handshake and status outputs decode the registered state only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_SHIFT);
    assign bcd_out   = bcd_q;
    assign zero_out  = zero_q;
`ifdef FRAC_RANGE_CHECK_EN
    assign out_ovf   = ovf_q;
`else
    // Saturation flag exists only with the range check; keep it constant.
    logic unused_ovf;
    assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_frac_bcd_seq.sv
// Testbench for frac_bcd_seq: table of conversions plus handshake,
// stall, ignored-input and mid-conversion reset sequences.
module tb_frac_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] frac_in;
    logic [4:0]  zero_in;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] bcd_out;
    logic [4:0]  zero_out;
    logic        busy;
`ifdef FRAC_RANGE_CHECK_EN
    logic        out_ovf;
`endif

    frac_bcd_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .frac_in   (frac_in),
        .zero_in   (zero_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .zero_out  (zero_out),
        .busy      (busy)
`ifdef FRAC_RANGE_CHECK_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [23:0] frac;
        logic [4:0]  zero;
        logic [19:0] bcd;
        logic        ovf;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one fraction in IDLE and return just after the accepting edge.
    task automatic start_conv(input logic [23:0] f, input logic [4:0] z);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        frac_in  = f;
        zero_in  = z;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        frac_in  = 24'h0ABCDE;
        zero_in  = 5'd31;
    endtask

    // Count edges until out_valid rises; bounded.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_and_check(input string name, input logic [23:0] f, input logic [4:0] z,
                                 input logic [19:0] eb, input logic [4:0] ez, input logic eo);
        int lat;
        start_conv(f, z);
        check({name, "_busy"}, {31'd0, busy}, 32'd1);
        wait_valid(lat);
        check({name, "_latency"}, lat, 32'd18);
        check({name, "_bcd"}, {12'd0, bcd_out}, {12'd0, eb});
        check({name, "_zero"}, {27'd0, zero_out}, {27'd0, ez});
`ifdef FRAC_RANGE_CHECK_EN
        check({name, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: ovf expectation undefined for %s", name);
`endif
        @(posedge clk);
        #1;
        check({name, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({name, "_ready_back"}, {31'd0, in_ready}, 32'd1);
        check({name, "_bcd_retained"}, {12'd0, bcd_out}, {12'd0, eb});
    endtask

    initial begin
        int  lat;
        logic spurious;

        vecs[0] = '{24'd0,      5'd0, 20'h00000, 1'b0};
        vecs[1] = '{24'd12345,  5'd0, 20'h12345, 1'b0};
        vecs[2] = '{24'd625,    5'd2, 20'h00625, 1'b0};
        vecs[3] = '{24'd99999,  5'd1, 20'h99999, 1'b0};
        vecs[4] = '{24'd1,      5'd4, 20'h00001, 1'b0};
        vecs[5] = '{24'hFE000C, 5'd7, 20'h00012, 1'b0};
`ifdef FRAC_RANGE_CHECK_EN
        vecs[6] = '{24'd100000, 5'd0, 20'h99999, 1'b1};
        vecs[7] = '{24'd5,      5'd3, 20'h00005, 1'b0};
        vecs[8] = '{24'd131071, 5'd0, 20'h99999, 1'b1};
`else
        vecs[6] = '{24'd100000, 5'd0, 20'h00000, 1'b0};
        vecs[7] = '{24'd5,      5'd3, 20'h00005, 1'b0};
        vecs[8] = '{24'd131071, 5'd0, 20'h31071, 1'b0};
`endif
        vecs[9] = '{24'd50000,  5'd0, 20'h50000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        frac_in   = '0;
        zero_in   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        check("rst_bcd",       {12'd0, bcd_out},   32'd0);
        check("rst_zero",      {27'd0, zero_out},  32'd0);
`ifdef FRAC_RANGE_CHECK_EN
        check("rst_ovf",       {31'd0, out_ovf},   32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].frac, vecs[i].zero,
                          vecs[i].bcd, vecs[i].zero, vecs[i].ovf);
        end

        // Consumer stall in DONE: outputs frozen, no new input accepted.
        out_ready = 1'b0;
        start_conv(24'd99999, 5'd0);
        wait_valid(lat);
        check("stall_latency", lat, 32'd18);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            frac_in  = 24'd11111;
            @(posedge clk);
            #1;
            check("stall_bcd",       {12'd0, bcd_out},   32'h99999);
            check("stall_out_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready",  {31'd0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_release_valid", {31'd0, out_valid}, 32'd0);
        check("stall_release_ready", {31'd0, in_ready},  32'd1);
        check("stall_release_bcd",   {12'd0, bcd_out},   32'h99999);

        // Input pulse during SHIFT is ignored.
        start_conv(24'd4321, 5'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("ign_busy",     {31'd0, busy},     32'd1);
        check("ign_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        frac_in  = 24'd55555;
        zero_in  = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(lat);
        check("ign_latency", lat + 6, 32'd18);
        check("ign_bcd",  {12'd0, bcd_out},  32'h04321);
        check("ign_zero", {27'd0, zero_out}, 32'd1);
        @(posedge clk);
        #1;
        spurious = 1'b0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid || busy) spurious = 1'b1;
            @(posedge clk);
            #1;
        end
        check("ign_no_second_result", {31'd0, spurious}, 32'd0);
        check("ign_bcd_kept", {12'd0, bcd_out}, 32'h04321);

        // Asynchronous reset in the middle of SHIFT (cnt = 8).
        start_conv(24'd77777, 5'd3);
        repeat (9) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_in_ready",  {31'd0, in_ready},  32'd1);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_busy",      {31'd0, busy},      32'd0);
        check("arst_bcd",       {12'd0, bcd_out},   32'd0);
        check("arst_zero",      {27'd0, zero_out},  32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("arst_hold_bcd", {12'd0, bcd_out}, 32'd0);
        run_and_check("post_rst", 24'd31250, 5'd0, 20'h31250, 5'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
